// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared types and constants for the ALU sequencer: operation
//            codes, sequencer states, flag bit positions, per-op flag masks,
//            ALU enable positions and the combinational op decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADC   = 4'd0,
    OP_SBC   = 4'd1,
    OP_CMP   = 4'd2,
    OP_AND   = 4'd3,
    OP_ORA   = 4'd4,
    OP_EOR   = 4'd5,
    OP_ASL   = 4'd6,
    OP_LSR   = 4'd7,
    OP_ROL   = 4'd8,
    OP_ROR   = 4'd9,
    OP_INC   = 4'd10,
    OP_DEC   = 4'd11,
    OP_BIT   = 4'd12,
    OP_IDX16 = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIX  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Bit positions inside the {N,V,Z,C} flag and mask vectors.
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] MASK_NVZC = 4'b1111;
  localparam logic [3:0] MASK_NZC  = 4'b1011;
  localparam logic [3:0] MASK_NZ   = 4'b1010;
  localparam logic [3:0] MASK_NVZ  = 4'b1110;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  // One-hot ALU enable positions.
  localparam int ALU_EN_W = 8;
  localparam int EN_SUM   = 0;
  localparam int EN_AND   = 1;
  localparam int EN_ORA   = 2;
  localparam int EN_EOR   = 3;
  localparam int EN_ASL   = 4;
  localparam int EN_LSR   = 5;
  localparam int EN_ROL   = 6;
  localparam int EN_ROR   = 7;

  typedef enum logic [1:0] {
    CIN_ZERO = 2'd0,
    CIN_ONE  = 2'd1,
    CIN_FLAG = 2'd2
  } cin_sel_e;

  typedef struct packed {
    logic [ALU_EN_W-1:0] en;
    logic                inv;
    cin_sel_e            cin_sel;
    logic                b_zero;
    logic [3:0]          mask;
    logic                wr;
  } op_ctrl_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_IDX16);
  endfunction

  // Pass-1 ALU controls, flag mask and write-back for each op. The IDX16
  // fix-up pass is a fixed a_hi+0+1 and is not described here.
  function automatic op_ctrl_t op_decode(input logic [3:0] op);
    op_ctrl_t ctl;
    ctl = '0;
    case (op)
      OP_ADC:   begin ctl.en[EN_SUM] = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NVZC; ctl.wr = 1'b1; end
      OP_SBC:   begin ctl.en[EN_SUM] = 1'b1; ctl.inv = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NVZC; ctl.wr = 1'b1; end
      OP_CMP:   begin ctl.en[EN_SUM] = 1'b1; ctl.inv = 1'b1; ctl.cin_sel = CIN_ONE; ctl.mask = MASK_NZC; end
      OP_AND:   begin ctl.en[EN_AND] = 1'b1; ctl.mask = MASK_NZ; ctl.wr = 1'b1; end
      OP_ORA:   begin ctl.en[EN_ORA] = 1'b1; ctl.mask = MASK_NZ; ctl.wr = 1'b1; end
      OP_EOR:   begin ctl.en[EN_EOR] = 1'b1; ctl.mask = MASK_NZ; ctl.wr = 1'b1; end
      OP_ASL:   begin ctl.en[EN_ASL] = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NZC; ctl.wr = 1'b1; end
      OP_LSR:   begin ctl.en[EN_LSR] = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NZC; ctl.wr = 1'b1; end
      OP_ROL:   begin ctl.en[EN_ROL] = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NZC; ctl.wr = 1'b1; end
      OP_ROR:   begin ctl.en[EN_ROR] = 1'b1; ctl.cin_sel = CIN_FLAG; ctl.mask = MASK_NZC; ctl.wr = 1'b1; end
      // INC/DEC use B=0: A+0+1 and A+FF+0 respectively.
      OP_INC:   begin ctl.en[EN_SUM] = 1'b1; ctl.b_zero = 1'b1; ctl.cin_sel = CIN_ONE; ctl.mask = MASK_NZ; ctl.wr = 1'b1; end
      OP_DEC:   begin ctl.en[EN_SUM] = 1'b1; ctl.b_zero = 1'b1; ctl.inv = 1'b1; ctl.mask = MASK_NZ; ctl.wr = 1'b1; end
      OP_BIT:   begin ctl.en[EN_AND] = 1'b1; ctl.mask = MASK_NVZ; end
      OP_IDX16: begin ctl.en[EN_SUM] = 1'b1; end
      default:  ctl = '0;
    endcase
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module   : ALU
// Purpose  : 8-bit combinational ALU: add with optional B inversion, AND,
//            ORA, EOR, and the four shift/rotate operations.
// Ports    : a, b      - operands (shifts use a only)
//            cin, inv  - carry in, invert b before the adder
//            en        - one-hot function enable; all-zero yields 0
//            res       - result byte
//            cout, ovf - carry out (shifted-out bit for shifts), signed
//                        overflow of the add; both 0 for logic ops
// Revision : 1.0 - initial release
// ============================================================================
module ALU
  import alu_seq_pkg::*;
(
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  input  logic                cin,
  input  logic                inv,
  input  logic [ALU_EN_W-1:0] en,
  output logic [7:0]          res,
  output logic                cout,
  output logic                ovf
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  always_comb begin
    b_eff = inv ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {8'h00, cin};
    res   = 8'h00;
    cout  = 1'b0;
    ovf   = 1'b0;
    if (en[EN_SUM]) begin
      res  = sum[7:0];
      cout = sum[8];
      // Overflow: both adder inputs share a sign that the result lacks.
      ovf  = (a[7] == b_eff[7]) && (sum[7] != a[7]);
    end else if (en[EN_AND]) begin
      res = a & b;
    end else if (en[EN_ORA]) begin
      res = a | b;
    end else if (en[EN_EOR]) begin
      res = a ^ b;
    end else if (en[EN_ASL]) begin
      res  = {a[6:0], 1'b0};
      cout = a[7];
    end else if (en[EN_LSR]) begin
      res  = {1'b0, a[7:1]};
      cout = a[0];
    end else if (en[EN_ROL]) begin
      res  = {a[6:0], cin};
      cout = a[7];
    end else if (en[EN_ROR]) begin
      res  = {cin, a[7:1]};
      cout = a[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Request/response controller owning the shared 8-bit ALU. Runs
//            one op per handshake, including the two-pass 16-bit indexed add.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            req_valid/req_ready       - request handshake (ready only in IDLE)
//            req_op, req_a, req_b,
//            req_a_hi, req_c           - op code, operands, base high, carry
//            rsp_valid/rsp_ready       - response handshake
//            rsp_data                  - {8'h00,result} or IDX16 address
//            rsp_wr, rsp_flags,
//            rsp_fmask                 - write-back, {N,V,Z,C}, update mask
//            rsp_page_cross, rsp_err   - IDX16 low carry, illegal op
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [7:0]  req_a_hi,
  input  logic        req_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_wr,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  rsp_fmask,
  output logic        rsp_page_cross,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d, a_hi_q, a_hi_d;
  logic        c_q, c_d;
  logic [15:0] data_q, data_d;
  logic        wr_q, wr_d, pc_q, pc_d, err_q, err_d;
  logic [3:0]  flags_q, flags_d, fmask_q, fmask_d;

  op_ctrl_t            ctl;
  logic [7:0]          alu_a, alu_b, alu_res;
  logic                alu_cin, alu_inv, alu_cout, alu_ovf;
  logic [ALU_EN_W-1:0] alu_en;
  logic [3:0]          flags_calc;

  // ALU drive: idle (all enables 0) except in EXEC and FIX.
  always_comb begin
    ctl     = op_decode(op_q);
    alu_a   = a_q;
    alu_b   = ctl.b_zero ? 8'h00 : b_q;
    alu_inv = 1'b0;
    alu_cin = 1'b0;
    alu_en  = '0;
    case (state_q)
      S_EXEC: begin
        alu_en  = ctl.en;
        alu_inv = ctl.inv;
        case (ctl.cin_sel)
          CIN_ONE:  alu_cin = 1'b1;
          CIN_FLAG: alu_cin = c_q;
          default:  alu_cin = 1'b0;
        endcase
      end
      S_FIX: begin
        // High-byte carry fix-up: a_hi + 0 + 1.
        alu_en[EN_SUM] = 1'b1;
        alu_a          = a_hi_q;
        alu_b          = 8'h00;
        alu_cin        = 1'b1;
      end
      default: ;
    endcase
  end

  ALU u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .cin  (alu_cin),
    .inv  (alu_inv),
    .en   (alu_en),
    .res  (alu_res),
    .cout (alu_cout),
    .ovf  (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    a_hi_d  = a_hi_q;
    c_d     = c_q;
    data_d  = data_q;
    wr_d    = wr_q;
    flags_d = flags_q;
    fmask_d = fmask_q;
    pc_d    = pc_q;
    err_d   = err_q;

    flags_calc         = 4'b0000;
    flags_calc[FLAG_N] = alu_res[7];
    flags_calc[FLAG_V] = alu_ovf;
    flags_calc[FLAG_Z] = (alu_res == 8'h00);
    flags_calc[FLAG_C] = alu_cout;
    // BIT takes N/V straight from the memory operand; Z still comes from A&B.
    if (op_q == OP_BIT) begin
      flags_calc[FLAG_N] = b_q[7];
      flags_calc[FLAG_V] = b_q[6];
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          a_d    = req_a;
          b_d    = req_b;
          a_hi_d = req_a_hi;
          c_d    = req_c;
          if (op_is_legal(req_op)) begin
            state_d = S_EXEC;
          end else begin
            // Illegal codes skip the ALU and answer on the next cycle.
            state_d = S_RESP;
            data_d  = 16'h0000;
            wr_d    = 1'b0;
            flags_d = 4'b0000;
            fmask_d = MASK_NONE;
            pc_d    = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        err_d = 1'b0;
        if (op_q == OP_IDX16) begin
          // High byte assumes no carry; FIX overwrites it if there was one.
          data_d  = {a_hi_q, alu_res};
          wr_d    = 1'b0;
          flags_d = 4'b0000;
          fmask_d = MASK_NONE;
          pc_d    = alu_cout;
          state_d = alu_cout ? S_FIX : S_RESP;
        end else begin
          data_d  = {8'h00, alu_res};
          wr_d    = ctl.wr;
          flags_d = flags_calc;
          fmask_d = ctl.mask;
          pc_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_FIX: begin
        data_d  = {alu_res, data_q[7:0]};
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      a_hi_q  <= 8'h00;
      c_q     <= 1'b0;
      data_q  <= 16'h0000;
      wr_q    <= 1'b0;
      flags_q <= 4'b0000;
      fmask_q <= 4'b0000;
      pc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_hi_q  <= a_hi_d;
      c_q     <= c_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      flags_q <= flags_d;
      fmask_q <= fmask_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = data_q;
  assign rsp_wr         = wr_q;
  assign rsp_flags      = flags_q;
  assign rsp_fmask      = fmask_q;
  assign rsp_page_cross = pc_q;
  assign rsp_err        = err_q;

endmodule
`default_nettype wire
